// File: rtl/io_ports_hs_if.sv
// CPU-side and external-side signals of the I/O port bank.
// clk and reset stay outside the interface.
interface io_ports_hs_if #(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 2
);
  logic                    we_port;
  logic                    re_port;
  logic [SEL_W-1:0]        port_sel;
  logic [WIDTH-1:0]        wdata;
  logic [WIDTH-1:0]        rdata;
  logic                    stall;
  logic [NPORTS*WIDTH-1:0] in_data;
  logic [NPORTS-1:0]       in_valid;
  logic [NPORTS-1:0]       in_ready;
  logic [NPORTS*WIDTH-1:0] out_data;
  logic [NPORTS-1:0]       out_valid;
  logic [NPORTS-1:0]       out_ready;
  logic [NPORTS-1:0]       irq_mask;
  logic                    irq;

  modport slave (
    input  we_port, re_port, port_sel, wdata, in_data, in_valid, out_ready, irq_mask,
    output rdata, stall, in_ready, out_data, out_valid, irq
  );

  modport master (
    output we_port, re_port, port_sel, wdata, in_data, in_valid, out_ready, irq_mask,
    input  rdata, stall, in_ready, out_data, out_valid, irq
  );
endinterface

// File: rtl/io_ports_hs.sv
// Parametrised I/O port bank: per-port one-entry input buffer and output register with
// valid/ready handshakes, CPU stall request and a registered maskable input interrupt.
module io_ports_hs_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] in_buf_o,
  output logic             in_full_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o
);
  logic [WIDTH-1:0] in_buf_q, in_buf_d, out_data_q, out_data_d;
  logic             in_full_q, in_full_d, out_valid_q, out_valid_d;

  // Capture needs an empty buffer and consume needs a full one, so they never collide.
  always_comb begin
    in_buf_d    = in_buf_q;
    in_full_d   = in_full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (in_valid_i && !in_full_q) begin
      in_buf_d  = in_data_i;
      in_full_d = 1'b1;
    end else if (rd_i) begin
      in_full_d = 1'b0;
    end
    if (wr_i) begin
      out_data_d  = wdata_i;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_q    <= '0;
      in_full_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      in_buf_q    <= in_buf_d;
      in_full_q   <= in_full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_buf_o    = in_buf_q;
  assign in_full_o   = in_full_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
endmodule

module io_ports_hs #(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 2
) (
  input  logic         clk,
  input  logic         reset,
  io_ports_hs_if.slave bus
);
  logic [NPORTS-1:0][WIDTH-1:0] in_data_a, in_buf_a, out_data_a;
  logic [NPORTS-1:0]            sel_hit, in_full, out_valid, wr, rd;
  logic                         stall_wr, stall_rd, stall;
  logic [WIDTH-1:0]             rdata;
  logic                         irq_q, irq_d;

  assign in_data_a = bus.in_data;

  // An out-of-range port_sel matches no lane, which silences writes, reads and stall.
  for (genvar k = 0; k < NPORTS; k++) begin : g_lane
    assign sel_hit[k] = (bus.port_sel == SEL_W'(k));
    assign wr[k]      = bus.we_port && sel_hit[k] && !stall;
    assign rd[k]      = bus.re_port && sel_hit[k] && !stall;

    io_ports_hs_lane #(.WIDTH(WIDTH)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .in_data_i   (in_data_a[k]),
      .in_valid_i  (bus.in_valid[k]),
      .rd_i        (rd[k]),
      .wr_i        (wr[k]),
      .wdata_i     (bus.wdata),
      .out_ready_i (bus.out_ready[k]),
      .in_buf_o    (in_buf_a[k]),
      .in_full_o   (in_full[k]),
      .out_data_o  (out_data_a[k]),
      .out_valid_o (out_valid[k])
    );
  end

  assign stall_wr = bus.we_port && |(sel_hit & out_valid & ~bus.out_ready);
  assign stall_rd = bus.re_port && |(sel_hit & ~in_full);
  assign stall    = stall_wr || stall_rd;

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NPORTS; k++)
      if (sel_hit[k]) rdata = rdata | in_buf_a[k];
  end

  assign irq_d = |(in_full & bus.irq_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.rdata     = rdata;
  assign bus.stall     = stall;
  assign bus.in_ready  = ~in_full;
  assign bus.out_data  = out_data_a;
  assign bus.out_valid = out_valid;
  assign bus.irq       = irq_q;
endmodule

// File: tb/tb_io_ports_hs.sv
// Directed bench for io_ports_hs: 4x8 bank for handshake/irq behaviour, 3x16 bank for out-of-range select.
module tb_io_ports_hs;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_ports_hs_if #(.NPORTS(4), .WIDTH(8),  .SEL_W(2)) ifa ();
  io_ports_hs_if #(.NPORTS(3), .WIDTH(16), .SEL_W(2)) ifb ();

  io_ports_hs #(.NPORTS(4), .WIDTH(8),  .SEL_W(2)) u_dut  (.clk(clk), .reset(reset), .bus(ifa));
  io_ports_hs #(.NPORTS(3), .WIDTH(16), .SEL_W(2)) u_dut3 (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.we_port = 0; ifa.re_port = 0; ifa.port_sel = '0; ifa.wdata = '0;
    ifa.in_data = '0; ifa.in_valid = '0; ifa.out_ready = '0; ifa.irq_mask = '0;
    ifb.we_port = 0; ifb.re_port = 0; ifb.port_sel = '0; ifb.wdata = '0;
    ifb.in_data = '0; ifb.in_valid = '0; ifb.out_ready = '0; ifb.irq_mask = '0;

    // 1. reset held with producers pushing on every port
    ifa.in_valid = 4'hF;
    ifa.in_data  = 32'h44332211;
    step(); step(); step();
    chk("rst_out_valid", ifa.out_valid, 4'h0);
    chk("rst_out_data",  ifa.out_data, 32'h0);
    chk("rst_in_ready",  ifa.in_ready, 4'hF);
    chk("rst_irq",       ifa.irq, 1'b0);
    chk("rst_rdata",     ifa.rdata, 8'h00);
    chk("rst_stall",     ifa.stall, 1'b0);

    // release with only port 2 offering data
    ifa.in_valid = 4'b0100;
    ifa.in_data  = 32'h00A50000;
    reset = 1'b1;
    #1;
    chk("rel_in_ready_pre", ifa.in_ready, 4'hF);
    step();
    ifa.in_valid = 4'b0000;
    chk("p2_in_ready", ifa.in_ready, 4'b1011);

    // 2. consume port 2
    ifa.port_sel = 2'd2; ifa.re_port = 1;
    #1;
    chk("p2_rdata", ifa.rdata, 8'hA5);
    chk("p2_stall", ifa.stall, 1'b0);
    step();
    ifa.re_port = 0;
    chk("p2_in_ready_after", ifa.in_ready, 4'hF);

    // 3. read from empty port 1 stalls until data arrives
    ifa.port_sel = 2'd1; ifa.re_port = 1;
    #1;
    chk("p1_stall_empty", ifa.stall, 1'b1);
    step();
    chk("p1_stall_hold", ifa.stall, 1'b1);
    ifa.in_valid = 4'b0010; ifa.in_data = 32'h00003C00;
    #1;
    chk("p1_stall_arrive", ifa.stall, 1'b1);
    step();
    ifa.in_valid = 4'b0000;
    #1;
    chk("p1_stall_clear", ifa.stall, 1'b0);
    chk("p1_rdata", ifa.rdata, 8'h3C);
    step();
    ifa.re_port = 0;
    chk("p1_in_ready", ifa.in_ready, 4'hF);

    // 4. output port 0 handshake
    ifa.port_sel = 2'd0; ifa.we_port = 1; ifa.wdata = 8'h11; ifa.out_ready = 4'b0000;
    #1;
    chk("o0_stall_first", ifa.stall, 1'b0);
    step();
    chk("o0_valid", ifa.out_valid, 4'b0001);
    chk("o0_data", ifa.out_data, 32'h00000011);
    ifa.wdata = 8'h22;
    #1;
    chk("o0_stall_full", ifa.stall, 1'b1);
    step();
    chk("o0_data_held", ifa.out_data, 32'h00000011);
    ifa.out_ready = 4'b0001;
    #1;
    chk("o0_stall_ready", ifa.stall, 1'b0);
    step();
    ifa.we_port = 0;
    chk("o0_data_new", ifa.out_data, 32'h00000022);
    chk("o0_valid_kept", ifa.out_valid, 4'b0001);
    step();
    ifa.out_ready = 4'b0000;
    chk("o0_drained", ifa.out_valid, 4'b0000);

    // 5. masked interrupt on port 3
    ifa.irq_mask = 4'b1000;
    ifa.in_valid = 4'b1000; ifa.in_data = 32'h77000000;
    step();
    ifa.in_valid = 4'b0000;
    chk("irq_in_ready3", ifa.in_ready, 4'b0111);
    chk("irq_lag", ifa.irq, 1'b0);
    step();
    chk("irq_set", ifa.irq, 1'b1);
    ifa.in_valid = 4'b0001; ifa.in_data = 32'h00000055;
    step();
    ifa.in_valid = 4'b0000;
    chk("irq_p0_full", ifa.in_ready, 4'b0110);
    step();
    chk("irq_unmasked_p0", ifa.irq, 1'b1);
    ifa.port_sel = 2'd3; ifa.re_port = 1;
    #1;
    chk("irq_rdata3", ifa.rdata, 8'h77);
    step();
    ifa.re_port = 0;
    chk("irq_in_ready3_back", ifa.in_ready, 4'b1110);
    chk("irq_still_high", ifa.irq, 1'b1);
    step();
    chk("irq_clear", ifa.irq, 1'b0);

    // 6. 3x16 bank: out-of-range select is inert
    ifb.in_valid = 3'b101; ifb.in_data = 48'hBEEF_0000_CAFE;
    step();
    ifb.in_valid = 3'b000;
    ifb.port_sel = 2'd0; ifb.we_port = 1; ifb.wdata = 16'h1234;
    step();
    chk("b_in_ready", ifb.in_ready, 3'b010);
    chk("b_out0", ifb.out_data, 48'h0000_0000_1234);
    ifb.port_sel = 2'd3; ifb.we_port = 1; ifb.re_port = 1; ifb.wdata = 16'hFFFF;
    #1;
    chk("b_oor_rdata", ifb.rdata, 16'h0000);
    chk("b_oor_stall", ifb.stall, 1'b0);
    step();
    chk("b_oor_out_data", ifb.out_data, 48'h0000_0000_1234);
    chk("b_oor_out_valid", ifb.out_valid, 3'b001);
    chk("b_oor_in_ready", ifb.in_ready, 3'b010);
    ifb.port_sel = 2'd2; ifb.we_port = 0; ifb.re_port = 1;
    #1;
    chk("b_p2_rdata", ifb.rdata, 16'hBEEF);
    step();
    ifb.re_port = 0;
    chk("b_p2_consumed", ifb.in_ready, 3'b110);
    ifb.we_port = 1; ifb.wdata = 16'hABCD;
    step();
    ifb.we_port = 0;
    chk("b_p2_out", ifb.out_data, 48'hABCD_0000_1234);
    chk("b_p2_valid", ifb.out_valid, 3'b101);
    ifb.port_sel = 2'd0;
    #1;
    chk("b_p0_rdata", ifb.rdata, 16'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
